// File: rtl/simprisc_dmem_if.sv
// Request/response bus between the SimpRisc load/store unit (master) and the
// data memory (slave), plus the write-snoop outputs driven by the memory.
interface simprisc_dmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // A transfer happens on a rising edge where valid & ready are both high;
    // valid must not depend on ready, and payload is stable while valid is
    // high and ready is low. The same rule holds on the request and response sides.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  snoop_valid;
    logic [ADDR_W-1:0]     snoop_addr_bus;
    logic [DATA_W-1:0]     snoop_data_bus;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  snoop_valid, snoop_addr_bus, snoop_data_bus
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output snoop_valid, snoop_addr_bus, snoop_data_bus
    );
endinterface

// File: rtl/simprisc_dmem.sv
// SimpRisc data memory: IDLE/WAIT/RESP slave with byte enables and error decode.
// Define SIMPRISC_DMEM_SNOOP_EN to build the write-snoop registers.
module simprisc_dmem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    simprisc_dmem_if.slave     bus,
    output logic [1:0]         state_dbg
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
    localparam state_t ACC_NEXT = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;

    state_t              state, next_state;
    logic [3:0]          cnt;
    logic                accept, enter_resp, commit;
    logic                cap_rw;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [BE_W-1:0]     cap_be;
    logic                op_rw, op_err;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata, merged;
    logic [BE_W-1:0]     op_be;
    logic [IDX_W-1:0]    op_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = ACC_NEXT;
            S_WAIT: if (cnt == 4'd0) next_state = S_RESP;
            S_RESP: if (bus.rsp_ready) next_state = accept ? ACC_NEXT : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = ~reset & ((state == S_IDLE) | ((state == S_RESP) & bus.rsp_ready));
        bus.rsp_valid = (state == S_RESP);
        accept        = bus.req_valid & bus.req_ready;
        // A held response (RESP without rsp_ready) is not a fresh entry.
        enter_resp    = (next_state == S_RESP) & ~((state == S_RESP) & ~bus.rsp_ready);
        state_dbg     = state;
    end

    always_ff @(posedge clk) begin
        if (reset)                               cnt <= 4'd0;
        else if (accept)                         cnt <= CNT_INIT;
        else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_rw    <= bus.req_rw;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
        end
    end

    // With no wait states RESP is entered on the accept edge itself, so the
    // operation comes straight from the bus instead of the capture registers.
    always_comb begin
        op_rw    = cap_rw;
        op_addr  = cap_addr;
        op_wdata = cap_wdata;
        op_be    = cap_be;
        if (WAIT_CYCLES == 0) begin
            op_rw    = bus.req_rw;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
            op_be    = bus.req_be;
        end
        op_idx = op_addr[OFF +: IDX_W];
        op_err = (|op_addr[OFF-1:0]) | (|(op_addr >> (OFF + IDX_W)));
        merged = mem[op_idx];
        for (int b = 0; b < BE_W; b++) begin
            if (op_be[b]) merged[b*8 +: 8] = op_wdata[b*8 +: 8];
        end
        commit = enter_resp & op_rw & ~op_err;
    end

    always_ff @(posedge clk) begin
        if (!reset && commit) mem[op_idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            bus.rsp_err   <= op_err;
            bus.rsp_rdata <= (op_rw | op_err) ? '0 : mem[op_idx];
        end
    end

`ifdef SIMPRISC_DMEM_SNOOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.snoop_valid    <= 1'b0;
            bus.snoop_addr_bus <= '0;
            bus.snoop_data_bus <= '0;
        end else begin
            bus.snoop_valid <= commit;
            if (commit) begin
                bus.snoop_addr_bus <= op_addr;
                bus.snoop_data_bus <= merged;
            end
        end
    end
`else
    always_comb begin
        bus.snoop_valid    = 1'b0;
        bus.snoop_addr_bus = '0;
        bus.snoop_data_bus = '0;
    end
`endif
endmodule
